// File: rtl/m20k_mem_pkg.sv
// Shared definitions for the M20K-class dual-port RAM: port operation
// decode and the masked-write merge used by both the array and the
// read forwarding path.
package m20k_mem_pkg;

  // Widest word the merge helper handles; narrower words are zero-extended.
  localparam int MERGE_W = 40;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } op_e;

  function automatic op_e decode_op(input logic ce, input logic we);
    if (!ce) return OP_IDLE;
    return we ? OP_WRITE : OP_READ;
  endfunction

  // Bits with wem=1 take d, all others keep old.
  function automatic logic [MERGE_W-1:0] merge_bits(input logic [MERGE_W-1:0] old_v,
                                                    input logic [MERGE_W-1:0] d_v,
                                                    input logic [MERGE_W-1:0] wem_v);
    return (old_v & ~wem_v) | (d_v & wem_v);
  endfunction

endpackage

// File: rtl/m20k_dp_core.sv
// Bare true-dual-port storage array. Two masked write ports (port 0 wins
// bitwise on a same-address double write) and two registered reads that
// return the pre-write contents. No reset on the array or read registers.
module m20k_dp_core
  import m20k_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we0,
  input  logic             we1,
  input  logic             re0,
  input  logic             re1,
  input  logic [AW-1:0]    a0,
  input  logic [AW-1:0]    a1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] wem0,
  input  logic [WIDTH-1:0] wem1,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr0_base;
  logic [WIDTH-1:0] wr0_data;
  logic [WIDTH-1:0] wr1_data;

  function automatic logic [WIDTH-1:0] mrg(input logic [WIDTH-1:0] old_v,
                                           input logic [WIDTH-1:0] d_v,
                                           input logic [WIDTH-1:0] wem_v);
    return WIDTH'(merge_bits(MERGE_W'(old_v), MERGE_W'(d_v), MERGE_W'(wem_v)));
  endfunction

  // Port 0 merges on top of port 1's result when both hit the same word.
  always_comb begin
    wr1_data = mrg(mem[a1], d1, wem1);
    wr0_base = (we1 && (a1 == a0)) ? wr1_data : mem[a0];
    wr0_data = mrg(wr0_base, d0, wem0);
  end

  // Array update and old-data synchronous reads; port 0 write issued last so it wins.
  always_ff @(posedge clk) begin
    if (we1) mem[a1] <= wr1_data;
    if (we0) mem[a0] <= wr0_data;
    if (re0) q0 <= mem[a0];
    if (re1) q1 <= mem[a1];
  end

endmodule

// File: rtl/m20k_dp_ram_param.sv
// Parametrised true-dual-port RAM leaf. Wraps the storage core with
// cross-port collision detection, write-to-read forwarding (so a read that
// coincides with a write on the other port sees the merged new data),
// read-valid strobes and an optional output register stage.
module m20k_dp_ram_param
  import m20k_mem_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2048,
  parameter int OUT_REG = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [AW-1:0]    A0,
  input  logic [AW-1:0]    A1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             CE0,
  input  logic             CE1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [WIDTH-1:0] WEM0,
  input  logic [WIDTH-1:0] WEM1,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             QV0,
  output logic             QV1,
  output logic             COLL
);

  op_e op0, op1;
  logic rd0, rd1, wr0, wr1;
  logic rd0_q, rd1_q, wr0_q, wr1_q, coll_q;
  logic [AW-1:0]    a0_q, a1_q;
  logic [WIDTH-1:0] d0_q, d1_q, wem0_q, wem1_q;
  logic [WIDTH-1:0] core_q0, core_q1;
  logic [WIDTH-1:0] fwd0, fwd1;

  function automatic logic [WIDTH-1:0] mrg(input logic [WIDTH-1:0] old_v,
                                           input logic [WIDTH-1:0] d_v,
                                           input logic [WIDTH-1:0] wem_v);
    return WIDTH'(merge_bits(MERGE_W'(old_v), MERGE_W'(d_v), MERGE_W'(wem_v)));
  endfunction

  assign op0 = decode_op(CE0, WE0);
  assign op1 = decode_op(CE1, WE1);
  assign rd0 = (op0 == OP_READ);
  assign rd1 = (op1 == OP_READ);
  assign wr0 = (op0 == OP_WRITE);
  assign wr1 = (op1 == OP_WRITE);

  m20k_dp_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk  (CLK),
    .we0  (wr0),
    .we1  (wr1),
    .re0  (rd0),
    .re1  (rd1),
    .a0   (A0),
    .a1   (A1),
    .d0   (D0),
    .d1   (D1),
    .wem0 (WEM0),
    .wem1 (WEM1),
    .q0   (core_q0),
    .q1   (core_q1)
  );

  // Capture each port's operation for forwarding, valid tracking and collision flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd0_q  <= 1'b0;
      rd1_q  <= 1'b0;
      wr0_q  <= 1'b0;
      wr1_q  <= 1'b0;
      coll_q <= 1'b0;
      a0_q   <= '0;
      a1_q   <= '0;
      d0_q   <= '0;
      d1_q   <= '0;
      wem0_q <= '0;
      wem1_q <= '0;
    end else begin
      rd0_q  <= rd0;
      rd1_q  <= rd1;
      wr0_q  <= wr0;
      wr1_q  <= wr1;
      coll_q <= (A0 == A1) && ((wr0 && (wr1 || rd1)) || (rd0 && wr1));
      a0_q   <= A0;
      a1_q   <= A1;
      d0_q   <= D0;
      d1_q   <= D1;
      wem0_q <= WEM0;
      wem1_q <= WEM1;
    end
  end

  // Core returns old data; overlay the other port's same-edge write on it.
  always_comb begin
    fwd0 = core_q0;
    fwd1 = core_q1;
    if (wr1_q && (a1_q == a0_q)) fwd0 = mrg(core_q0, d1_q, wem1_q);
    if (wr0_q && (a0_q == a1_q)) fwd1 = mrg(core_q1, d0_q, wem0_q);
  end

  generate
    if (OUT_REG == 0) begin : g_direct
      logic [WIDTH-1:0] hold0, hold1;

      // Remember the last completed read so Q holds between reads.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          hold0 <= '0;
          hold1 <= '0;
        end else begin
          if (rd0_q) hold0 <= fwd0;
          if (rd1_q) hold1 <= fwd1;
        end
      end

      assign Q0  = rd0_q ? fwd0 : hold0;
      assign Q1  = rd1_q ? fwd1 : hold1;
      assign QV0 = rd0_q;
      assign QV1 = rd1_q;
    end else begin : g_outreg
      logic [WIDTH-1:0] q0_r, q1_r;
      logic qv0_r, qv1_r;

      // Extra output stage; data register only loads when a read completes.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          q0_r  <= '0;
          q1_r  <= '0;
          qv0_r <= 1'b0;
          qv1_r <= 1'b0;
        end else begin
          qv0_r <= rd0_q;
          qv1_r <= rd1_q;
          if (rd0_q) q0_r <= fwd0;
          if (rd1_q) q1_r <= fwd1;
        end
      end

      assign Q0  = q0_r;
      assign Q1  = q1_r;
      assign QV0 = qv0_r;
      assign QV1 = qv1_r;
    end
  endgenerate

  assign COLL = coll_q;

endmodule

// File: tb/tb_m20k_dp_ram_param.sv
// Directed bench for m20k_dp_ram_param. Two instances share all inputs:
// dut_a without and dut_b with the output register stage.
module tb_m20k_dp_ram_param;

  logic        clk;
  logic        rstn;
  logic [10:0] a0, a1;
  logic [7:0]  d0, d1, wem0, wem1;
  logic        ce0, ce1, we0, we1;
  logic [7:0]  q0_a, q1_a, q0_b, q1_b;
  logic        qv0_a, qv1_a, qv0_b, qv1_b, coll_a, coll_b;

  int n_total = 0;
  int n_pass  = 0;

  m20k_dp_ram_param #(.WIDTH(8), .DEPTH(2048), .OUT_REG(0)) dut_a (
    .CLK(clk), .RSTN(rstn), .A0(a0), .A1(a1), .D0(d0), .D1(d1),
    .CE0(ce0), .CE1(ce1), .WE0(we0), .WE1(we1), .WEM0(wem0), .WEM1(wem1),
    .Q0(q0_a), .Q1(q1_a), .QV0(qv0_a), .QV1(qv1_a), .COLL(coll_a)
  );

  m20k_dp_ram_param #(.WIDTH(8), .DEPTH(2048), .OUT_REG(1)) dut_b (
    .CLK(clk), .RSTN(rstn), .A0(a0), .A1(a1), .D0(d0), .D1(d1),
    .CE0(ce0), .CE1(ce1), .WE0(we0), .WE1(we1), .WEM0(wem0), .WEM1(wem1),
    .Q0(q0_b), .Q1(q1_b), .QV0(qv0_b), .QV1(qv1_b), .COLL(coll_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce0 = 0; we0 = 0; a0 = '0; d0 = '0; wem0 = '0;
    ce1 = 0; we1 = 0; a1 = '0; d1 = '0; wem1 = '0;
  endtask

  task automatic set_p0(input logic we, input logic [10:0] a, input logic [7:0] d, input logic [7:0] wem);
    ce0 = 1; we0 = we; a0 = a; d0 = d; wem0 = wem;
  endtask

  task automatic set_p1(input logic we, input logic [10:0] a, input logic [7:0] d, input logic [7:0] wem);
    ce1 = 1; we1 = we; a1 = a; d1 = d; wem1 = wem;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle();
    #2;
    n_total++;
    if ({q0_a, q1_a, qv0_a, qv1_a, coll_a} !== 19'd0)
      $display("FAIL reset_a: got %h expected 0", {q0_a, q1_a, qv0_a, qv1_a, coll_a});
    else n_pass++;
    n_total++;
    if ({q0_b, q1_b, qv0_b, qv1_b, coll_b} !== 19'd0)
      $display("FAIL reset_b: got %h expected 0", {q0_b, q1_b, qv0_b, qv1_b, coll_b});
    else n_pass++;
    tick();
    tick();
    #3 rstn = 1;
    tick();
  endtask

  task automatic test_write_read();
    set_p0(1, 11'h010, 8'hA5, 8'hFF);
    tick();
    idle();
    set_p1(0, 11'h010, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q1_a !== 8'hA5 || qv1_a !== 1'b1)
      $display("FAIL wr_rd_a: got q=%h qv=%b expected q=a5 qv=1", q1_a, qv1_a);
    else n_pass++;
    n_total++;
    if (qv1_b !== 1'b0 || coll_a !== 1'b0)
      $display("FAIL wr_rd_early: got qv1_b=%b coll=%b expected 0 0", qv1_b, coll_a);
    else n_pass++;
    tick();
    n_total++;
    if (q1_b !== 8'hA5 || qv1_b !== 1'b1)
      $display("FAIL wr_rd_b: got q=%h qv=%b expected q=a5 qv=1", q1_b, qv1_b);
    else n_pass++;
    n_total++;
    if (q1_a !== 8'hA5 || qv1_a !== 1'b0)
      $display("FAIL wr_rd_hold_a: got q=%h qv=%b expected q=a5 qv=0", q1_a, qv1_a);
    else n_pass++;
    tick();
    n_total++;
    if (q1_b !== 8'hA5 || qv1_b !== 1'b0)
      $display("FAIL wr_rd_hold_b: got q=%h qv=%b expected q=a5 qv=0", q1_b, qv1_b);
    else n_pass++;
  endtask

  task automatic test_mask();
    set_p0(1, 11'h020, 8'hFF, 8'hFF);
    tick();
    set_p0(1, 11'h020, 8'h00, 8'h0F);
    tick();
    set_p0(0, 11'h020, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q0_a !== 8'hF0 || qv0_a !== 1'b1)
      $display("FAIL mask_a: got q=%h qv=%b expected q=f0 qv=1", q0_a, qv0_a);
    else n_pass++;
    set_p0(1, 11'h020, 8'h5A, 8'h00);
    tick();
    idle();
    n_total++;
    if (q0_b !== 8'hF0 || qv0_a !== 1'b0 || q0_a !== 8'hF0)
      $display("FAIL mask_b_hold: got q0_b=%h qv0_a=%b q0_a=%h expected f0 0 f0", q0_b, qv0_a, q0_a);
    else n_pass++;
    set_p0(0, 11'h020, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q0_a !== 8'hF0 || qv0_a !== 1'b1)
      $display("FAIL mask_zero_wem: got q=%h qv=%b expected q=f0 qv=1", q0_a, qv0_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_mixed();
    set_p0(1, 11'h7FF, 8'h11, 8'hFF);
    tick();
    idle();
    set_p0(1, 11'h7FF, 8'h3C, 8'hFF);
    set_p1(0, 11'h7FF, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q1_a !== 8'h3C || qv1_a !== 1'b1)
      $display("FAIL mixed_q1_a: got q=%h qv=%b expected q=3c qv=1", q1_a, qv1_a);
    else n_pass++;
    n_total++;
    if (coll_a !== 1'b1 || coll_b !== 1'b1)
      $display("FAIL mixed_coll: got a=%b b=%b expected 1 1", coll_a, coll_b);
    else n_pass++;
    tick();
    n_total++;
    if (q1_b !== 8'h3C || coll_a !== 1'b0)
      $display("FAIL mixed_q1_b: got q=%h coll=%b expected q=3c coll=0", q1_b, coll_a);
    else n_pass++;
    set_p1(1, 11'h7FF, 8'hF0, 8'hF0);
    set_p0(0, 11'h7FF, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q0_a !== 8'hFC || coll_a !== 1'b1)
      $display("FAIL mixed_rev_a: got q=%h coll=%b expected q=fc coll=1", q0_a, coll_a);
    else n_pass++;
    tick();
    n_total++;
    if (q0_b !== 8'hFC)
      $display("FAIL mixed_rev_b: got %h expected fc", q0_b);
    else n_pass++;
  endtask

  task automatic test_write_write();
    set_p0(1, 11'h100, 8'h00, 8'hFF);
    tick();
    set_p0(1, 11'h100, 8'hAA, 8'hF0);
    set_p1(1, 11'h100, 8'h55, 8'hFF);
    tick();
    idle();
    n_total++;
    if (coll_a !== 1'b1 || coll_b !== 1'b1)
      $display("FAIL ww_coll: got a=%b b=%b expected 1 1", coll_a, coll_b);
    else n_pass++;
    set_p0(0, 11'h100, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q0_a !== 8'hA5 || coll_a !== 1'b0)
      $display("FAIL ww_data_a: got q=%h coll=%b expected q=a5 coll=0", q0_a, coll_a);
    else n_pass++;
    tick();
    n_total++;
    if (q0_b !== 8'hA5)
      $display("FAIL ww_data_b: got %h expected a5", q0_b);
    else n_pass++;
  endtask

  task automatic test_read_read();
    set_p0(0, 11'h020, 8'h00, 8'h00);
    set_p1(0, 11'h020, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q0_a !== 8'hF0 || q1_a !== 8'hF0 || coll_a !== 1'b0)
      $display("FAIL rr_a: got q0=%h q1=%h coll=%b expected f0 f0 0", q0_a, q1_a, coll_a);
    else n_pass++;
    tick();
    n_total++;
    if (q0_b !== 8'hF0 || q1_b !== 8'hF0 || qv0_b !== 1'b1 || qv1_b !== 1'b1)
      $display("FAIL rr_b: got q0=%h q1=%h qv=%b%b expected f0 f0 11", q0_b, q1_b, qv0_b, qv1_b);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] addr_v [4] = '{11'h010, 11'h020, 11'h7FF, 11'h100};
    logic [7:0]  exp_v  [4] = '{8'hA5, 8'hF0, 8'hFC, 8'hA5};
    for (int i = 0; i < 4; i++) begin
      set_p0(0, addr_v[i], 8'h00, 8'h00);
      tick();
      n_total++;
      if (q0_a !== exp_v[i] || qv0_a !== 1'b1)
        $display("FAIL b2b_a[%0d]: got q=%h qv=%b expected q=%h qv=1", i, q0_a, qv0_a, exp_v[i]);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (q0_b !== exp_v[i-1] || qv0_b !== 1'b1)
          $display("FAIL b2b_b[%0d]: got q=%h qv=%b expected q=%h qv=1", i, q0_b, qv0_b, exp_v[i-1]);
        else n_pass++;
      end
    end
    idle();
    tick();
    n_total++;
    if (q0_b !== exp_v[3] || qv0_b !== 1'b1 || qv0_a !== 1'b0)
      $display("FAIL b2b_tail: got q0_b=%h qv0_b=%b qv0_a=%b expected a5 1 0", q0_b, qv0_b, qv0_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    set_p0(0, 11'h010, 8'h00, 8'h00);
    set_p1(0, 11'h020, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (qv0_a !== 1'b1 || qv1_a !== 1'b1)
      $display("FAIL rstmid_pre: got qv=%b%b expected 11", qv0_a, qv1_a);
    else n_pass++;
    #2 rstn = 0;
    #1;
    n_total++;
    if ({q0_a, q1_a, qv0_a, qv1_a, coll_a} !== 19'd0)
      $display("FAIL rstmid_a: got %h expected 0", {q0_a, q1_a, qv0_a, qv1_a, coll_a});
    else n_pass++;
    n_total++;
    if ({q0_b, q1_b, qv0_b, qv1_b, coll_b} !== 19'd0)
      $display("FAIL rstmid_b: got %h expected 0", {q0_b, q1_b, qv0_b, qv1_b, coll_b});
    else n_pass++;
    tick();
    #3 rstn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({qv0_a, qv1_a, qv0_b, qv1_b} !== 4'b0000)
        $display("FAIL rstmid_noqv[%0d]: got %b expected 0000", i, {qv0_a, qv1_a, qv0_b, qv1_b});
      else n_pass++;
    end
    set_p0(0, 11'h010, 8'h00, 8'h00);
    tick();
    idle();
    n_total++;
    if (q0_a !== 8'hA5 || qv0_a !== 1'b1)
      $display("FAIL rstmid_keep_a: got q=%h qv=%b expected q=a5 qv=1", q0_a, qv0_a);
    else n_pass++;
    tick();
    n_total++;
    if (q0_b !== 8'hA5 || qv0_b !== 1'b1)
      $display("FAIL rstmid_keep_b: got q=%h qv=%b expected q=a5 qv=1", q0_b, qv0_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_mixed();
    test_write_write();
    test_read_read();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
